ofs_plat_utils_ccip_wr_bmask_merge: RTL and testbench
=====================================================

Name: ofs_plat_utils_ccip_wr_bmask_merge

Overview:
Write-combining stage that sits upstream of the CCI-P byte-range-to-mask decode on the host-channel write path. It accepts CCI-P line writes carrying byte_start/byte_len partial-write fields and holds one line in a merge register. Successive partial writes to the same line address are coalesced into one write with a merged byte mask. The output feeds Avalon/AXI masked-write generation. This cuts host traffic for byte-granular AFU writes.

Parameters:
ADDR_WIDTH, 42, CCI-P line address width
DATA_WIDTH, 512, line data width; byte count NB = DATA_WIDTH/8 = 64
MDATA_WIDTH, 16, request metadata width
MAX_MERGE, 8, maximum requests combined into one output write
TIMEOUT_CYCLES, 16, idle cycles before a held line is forced out (≥1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  write request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_addr  in  ADDR_WIDTH  line address
in_data  in  DATA_WIDTH  line data
in_byte_en  in  1  0 = full-line write; 1 = partial write using start/len
in_byte_start  in  6  first byte index
in_byte_len  in  6  byte count; start+len mod 64, where result 0 means end of line
in_mdata  in  MDATA_WIDTH  metadata
flush  in  1  force held line out
out_valid  out  1  merged write valid
out_ready  in  1  downstream accept
out_addr  out  ADDR_WIDTH  line address
out_data  out  DATA_WIDTH  merged data
out_bmask  out  NB  merged byte mask
out_mdata  out  MDATA_WIDTH  mdata of the last merged request
out_merge_cnt  out  $clog2(MAX_MERGE+1)  requests merged (1..MAX_MERGE)

Behaviour:
- States: EMPTY, HOLD, DRAIN. Reset forces EMPTY, idle counter 0, merge count 0, out_valid 0. All datapath registers are don't-care.
- out_valid = (state==DRAIN). Outputs are driven from registers only.
- Request mask: all ones when in_byte_en=0. Otherwise bit i is set iff start ≤ i < end, where end = (start+len) mod 64 and end 0 is treated as 64.
- in_byte_en=1 with in_byte_len=0 is a protocol violation, flagged by a simulation assertion. Behaviour is undefined.
- in_ready:
  - EMPTY: 1.
  - HOLD: 1 iff !flush && in_addr==held addr && merge count<MAX_MERGE. This combinational dependence on in_addr is intentional.
  - DRAIN: out_ready.
- EMPTY, on accept: load addr, data, mask and mdata; merge count=1; idle=0. Go to HOLD, or to DRAIN if the mask is all ones.
- HOLD, on accept (merge):
  - Byte i of the held data takes in_data byte i where the new mask bit is set; otherwise it keeps the held byte.
  - mask |= new mask; mdata = in_mdata; merge count+1; idle=0.
  - Go to DRAIN next cycle if the merged mask is all ones or merge count reaches MAX_MERGE; else stay in HOLD.
- HOLD, no accept:
  - Go to DRAIN if flush, an address mismatch with in_valid, merge count==MAX_MERGE with in_valid, or idle==TIMEOUT_CYCLES-1.
  - Otherwise idle+1.
  - Result: a lone held line presents out_valid TIMEOUT_CYCLES+1 cycles after its accepting cycle.
- DRAIN:
  - Hold the outputs stable until out_ready.
  - On out_ready with an input accept in the same cycle: load the new request as in EMPTY (back-to-back, no bubble).
  - On out_ready without accept: go to EMPTY.
- flush in EMPTY or DRAIN: no effect.
- An address mismatch costs exactly one cycle: the HOLD→DRAIN transition. The new request is accepted in the DRAIN cycle that sees out_ready.
- Reset mid-HOLD or mid-DRAIN discards the held line without emitting it.
- No reordering. Output writes appear in first-accept order, and no byte is ever dropped.

Test Plan:
1. Partial write addr 0x10, start 4, len 8, then idle → out_bmask=0x0000_0000_0000_0FF0, merge_cnt 1, out_valid exactly 17 cycles after the accept.
2. Two writes to 0x20, (start 0, len 4, data bytes AA) then (start 2, len 4, bytes BB) → mask 0x3F; bytes 0–1=AA, 2–5=BB; out_mdata = second mdata; merge_cnt 2.
3. Write to 0x30 then write to 0x31 on the next cycle → in_ready=0 for one cycle. 0x30 is emitted, then 0x31 is accepted with out_ready=1 and no further bubble.
4. in_byte_en=0 write → DRAIN the next cycle, mask all ones, no timeout wait. Also start 60, len 4 (end wraps to 0) → mask bits 60–63 only.
5. 9 partial writes to one address with MAX_MERGE=8 and out_ready held 0 for 5 cycles → first output has merge_cnt 8 and is stable through backpressure. Ninth request then yields a second output with merge_cnt 1.
6. HOLD with flush=1 → DRAIN the next cycle, in_ready=0 that cycle. Reset asserted in HOLD → state EMPTY, no output.

Source files
------------

// File: rtl/ofs_plat_utils_ccip_wr_bmask_merge.sv
// Write-combining merge stage for CCI-P partial line writes.
// Coalesces same-address byte-range writes into one masked write.
`timescale 1ns/1ps
module ofs_plat_utils_ccip_wr_bmask_merge #(
  parameter int ADDR_WIDTH     = 42,
  parameter int DATA_WIDTH     = 512,
  parameter int MDATA_WIDTH    = 16,
  parameter int MAX_MERGE      = 8,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int NB = DATA_WIDTH / 8,
  localparam int CW = $clog2(MAX_MERGE + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_byte_en,
  input  logic [5:0]             in_byte_start,
  input  logic [5:0]             in_byte_len,
  input  logic [MDATA_WIDTH-1:0] in_mdata,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [NB-1:0]          out_bmask,
  output logic [MDATA_WIDTH-1:0] out_mdata,
  output logic [CW-1:0]          out_merge_cnt
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [NB-1:0]          r_mask;
  logic [MDATA_WIDTH-1:0] r_mdata;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idle;

  logic [6:0]             w_sum;
  logic [6:0]             w_end;
  logic [NB-1:0]          w_req_mask;
  logic [NB-1:0]          w_merge_mask;
  logic [DATA_WIDTH-1:0]  w_merge_data;
  logic                   w_in_ready;
  logic                   w_acc;
  logic                   w_addr_hit;
  logic                   w_cnt_full;
  logic                   w_cnt_last;
  logic                   w_idle_exp;
  logic                   w_load;
  logic                   w_merge;

  // End index wraps mod 64; an end of 0 means the range runs to the line end.
  always_comb begin
    w_sum = {1'b0, in_byte_start} + {1'b0, in_byte_len};
    w_end = (w_sum[5:0] == 6'd0) ? 7'd64 : {1'b0, w_sum[5:0]};
    w_req_mask = '0;
    for (int i = 0; i < NB; i++) begin
      w_req_mask[i] = !in_byte_en ||
        ((7'(i) >= {1'b0, in_byte_start}) && (7'(i) < w_end));
    end
  end

  always_comb begin
    w_merge_data = r_data;
    for (int i = 0; i < NB; i++) begin
      if (w_req_mask[i]) begin
        w_merge_data[i*8 +: 8] = in_data[i*8 +: 8];
      end
    end
  end

  assign w_merge_mask = r_mask | w_req_mask;
  assign w_addr_hit   = (in_addr == r_addr);
  assign w_cnt_full   = (r_cnt == CW'(MAX_MERGE));
  assign w_cnt_last   = (r_cnt == CW'(MAX_MERGE - 1));
  assign w_idle_exp   = (r_idle == IW'(TIMEOUT_CYCLES - 1));

  assign w_acc   = in_valid && w_in_ready;
  assign w_merge = w_acc && (r_state == S_HOLD);
  assign w_load  = w_acc && (r_state != S_HOLD);

  // Output / handshake decode
  always_comb begin
    out_valid  = (r_state == S_DRAIN);
    w_in_ready = 1'b0;
    unique case (r_state)
      S_EMPTY: w_in_ready = 1'b1;
      S_HOLD:  w_in_ready = !flush && w_addr_hit && !w_cnt_full;
      S_DRAIN: w_in_ready = out_ready;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign in_ready = w_in_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_next = (&w_req_mask) ? S_DRAIN : S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_acc) begin
          if ((&w_merge_mask) || w_cnt_last) begin
            w_next = S_DRAIN;
          end
        end else if (flush || w_idle_exp ||
                     (in_valid && (!w_addr_hit || w_cnt_full))) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (w_acc) begin
            w_next = (&w_req_mask) ? S_DRAIN : S_HOLD;
          end else begin
            w_next = S_EMPTY;
          end
        end
      end
      default: w_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_cnt   <= '0;
      r_idle  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_cnt  <= CW'(1);
        r_idle <= '0;
      end else if (w_merge) begin
        r_cnt  <= r_cnt + CW'(1);
        r_idle <= '0;
      end else if (r_state == S_HOLD && w_next == S_HOLD) begin
        r_idle <= r_idle + IW'(1);
      end else if (r_state == S_DRAIN && w_next == S_EMPTY) begin
        r_cnt  <= '0;
      end
    end
  end

  // Datapath needs no reset; contents are only observed in DRAIN.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_addr  <= in_addr;
      r_data  <= in_data;
      r_mask  <= w_req_mask;
      r_mdata <= in_mdata;
    end else if (w_merge) begin
      r_data  <= w_merge_data;
      r_mask  <= w_merge_mask;
      r_mdata <= in_mdata;
    end
  end

  assign out_addr      = r_addr;
  assign out_data      = r_data;
  assign out_bmask     = r_mask;
  assign out_mdata     = r_mdata;
  assign out_merge_cnt = r_cnt;

  a_len_zero: assert property (
    @(posedge clk) disable iff (reset)
      !(in_valid && in_byte_en && (in_byte_len == 6'd0))
  ) else $error("partial write with zero byte length");

endmodule

// File: tb/tb_ofs_plat_utils_ccip_wr_bmask_merge.sv
// Scoreboard bench for the write-combining merge stage.
// Directed vectors, expected writes queued at issue time.
`timescale 1ns/1ps
module tb_ofs_plat_utils_ccip_wr_bmask_merge;

  localparam int AW = 42;
  localparam int DW = 512;
  localparam int MW = 16;
  localparam int MM = 8;
  localparam int TO = 16;
  localparam int NB = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_byte_en;
  logic [5:0]    in_byte_start;
  logic [5:0]    in_byte_len;
  logic [MW-1:0] in_mdata;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [NB-1:0] out_bmask;
  logic [MW-1:0] out_mdata;
  logic [CW-1:0] out_merge_cnt;

  always #5 clk = ~clk;

  ofs_plat_utils_ccip_wr_bmask_merge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MDATA_WIDTH(MW),
    .MAX_MERGE(MM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .in_byte_en(in_byte_en), .in_byte_start(in_byte_start),
    .in_byte_len(in_byte_len), .in_mdata(in_mdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .out_bmask(out_bmask), .out_mdata(out_mdata),
    .out_merge_cnt(out_merge_cnt)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NB-1:0] mask;
    logic [MW-1:0] mdata;
    int            cnt;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] bexp(input logic [NB-1:0] m);
    logic [DW-1:0] r;
    for (int i = 0; i < NB; i++) r[i*8 +: 8] = m[i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {NB{b}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NB-1:0] m, input logic [MW-1:0] md,
                      input int c);
    exp_t e;
    e.addr = a; e.data = d; e.mask = m; e.mdata = md; e.cnt = c;
    sb.push_back(e);
  endtask

  // Called and returns at posedge+1; reports cycles spent not ready.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic be, input logic [5:0] s,
                      input logic [5:0] l, input logic [MW-1:0] md,
                      output int stalls);
    in_valid = 1'b1; in_addr = a; in_data = d; in_byte_en = be;
    in_byte_start = s; in_byte_len = l; in_mdata = md;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: addr %0h never accepted", a);
        break;
      end
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain_wait(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d writes still pending, required 0",
               nm, sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compare each accepted output against the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: addr %0h got, none expected",
                 out_addr);
      end else begin
        m_e = sb.pop_front();
        chk("out_addr", 64'(out_addr), 64'(m_e.addr));
        chk("out_bmask", out_bmask, m_e.mask);
        chk("out_mdata", 64'(out_mdata), 64'(m_e.mdata));
        chk("out_merge_cnt", 64'(out_merge_cnt), 64'(m_e.cnt));
        checks++;
        if ((out_data & bexp(m_e.mask)) !== (m_e.data & bexp(m_e.mask))) begin
          errors++;
          $display("FAIL out_data: addr %0h got %0h expected %0h",
                   m_e.addr, out_data & bexp(m_e.mask),
                   m_e.data & bexp(m_e.mask));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int n;
    int a;
    int cntv;
    logic [DW-1:0] d;

    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    in_byte_en = 1'b0; in_byte_start = '0; in_byte_len = '0;
    in_mdata = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // T1: lone partial write, timeout drain
    push(42'h10, fill(8'h11), 64'h0FF0, 16'h0001, 1);
    send(42'h10, fill(8'h11), 1'b1, 6'd4, 6'd8, 16'h0001, st);
    a = acc_cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    chk("t1_latency_edges", 64'(cyc - a), 64'(TO));
    drain_wait("t1_drain");

    // T2: two overlapping writes merge
    d = fill(8'hBB);
    d[15:0] = 16'hAAAA;
    push(42'h20, d, 64'h3F, 16'h0003, 2);
    send(42'h20, fill(8'hAA), 1'b1, 6'd0, 6'd4, 16'h0002, st);
    send(42'h20, fill(8'hBB), 1'b1, 6'd2, 6'd4, 16'h0003, st);
    chk("t2_stall", 64'(st), 64'd0);
    drain_wait("t2_drain");

    // T3: address mismatch costs one cycle
    push(42'h30, fill(8'h30), 64'h1, 16'h0004, 1);
    push(42'h31, fill(8'h31), 64'h1, 16'h0005, 1);
    send(42'h30, fill(8'h30), 1'b1, 6'd0, 6'd1, 16'h0004, st);
    send(42'h31, fill(8'h31), 1'b1, 6'd0, 6'd1, 16'h0005, st);
    chk("t3_stall", 64'(st), 64'd1);
    drain_wait("t3_drain");

    // T4: full-line write and wrapped end
    push(42'h40, fill(8'h44), {NB{1'b1}}, 16'h0006, 1);
    send(42'h40, fill(8'h44), 1'b0, 6'd0, 6'd0, 16'h0006, st);
    @(negedge clk);
    chk("t4_drain_next", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    push(42'h41, fill(8'h41), 64'hF000_0000_0000_0000, 16'h0007, 1);
    send(42'h41, fill(8'h41), 1'b1, 6'd60, 6'd4, 16'h0007, st);
    drain_wait("t4_drain");

    // T5: merge limit under backpressure
    out_ready = 1'b0;
    d = '0;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(8'h50 + i);
    push(42'h50, d, 64'hFF, 16'h0107, 8);
    push(42'h50, fill(8'h58), 64'h100, 16'h0108, 1);
    fork
      begin
        int s2;
        for (int i = 0; i < 9; i++)
          send(42'h50, fill(8'(8'h50 + i)), 1'b1, 6'(i), 6'd1,
               16'(16'h100 + i), s2);
      end
      begin
        int n2;
        n2 = 0;
        do begin @(negedge clk); n2++; end
        while (!out_valid && n2 < 100);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          chk("t5_hold_valid", 64'(out_valid), 64'd1);
          chk("t5_hold_mask", out_bmask, 64'hFF);
          chk("t5_hold_cnt", 64'(out_merge_cnt), 64'd8);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain_wait("t5_drain");

    // T6: flush, then reset discarding a held line
    push(42'h60, fill(8'h66), 64'h3, 16'h0009, 1);
    send(42'h60, fill(8'h66), 1'b1, 6'd0, 6'd2, 16'h0009, st);
    flush = 1'b1;
    @(negedge clk);
    chk("t6_flush_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t6_flush_drain", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    drain_wait("t6_drain");

    send(42'h70, fill(8'h77), 1'b1, 6'd0, 6'd1, 16'h000A, st);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
    cntv = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) cntv++;
    end
    chk("t6_rst_no_emit", 64'(cntv), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
